// File: rtl/lane_overlay_ctrl.sv
// Frame sequencer for the lane overlay path: shadows lane line parameters, commits them
// atomically at frame start and raster-scans pixel coordinates under downstream backpressure.
module lane_overlay_ctrl #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        CLK100MHZ,
  input  logic        RESET,
  input  logic        param_valid,
  output logic        param_ready,
  input  logic        param_lane,
  input  logic [15:0] param_m,
  input  logic [15:0] param_b,
  input  logic        frame_start,
  input  logic        px_ready,
  output logic        px_valid,
  output logic [15:0] x_coord,
  output logic [15:0] y_coord,
  output logic [15:0] m_left,
  output logic [15:0] b_left,
  output logic [15:0] m_right,
  output logic [15:0] b_right,
  output logic [1:0]  lane_en,
  output logic        ovl_valid,
  output logic        frame_done,
  output logic        frame_overrun,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  // Handshakes: a transfer happens on a rising clock edge where valid and ready are both
  // high; ready may depend combinationally on valid-side inputs, never the reverse.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] X_LAST = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(IMG_HEIGHT - 1);

  state_t            state_q, state_d;
  logic [15:0]       x_q, x_d, y_q, y_d;
  logic [1:0][15:0]  sh_m_q, sh_m_d, sh_b_q, sh_b_d;
  logic [1:0][15:0]  act_m_q, act_m_d, act_b_q, act_b_d;
  logic [1:0]        sh_v_q, sh_v_d, lane_en_q, lane_en_d;
  logic              ovl_q, ovl_d, ovr_q, ovr_d;

  logic commit, px_acc, last_px, param_acc;

  assign commit    = (state_q == ST_IDLE) && frame_start;
  assign px_acc    = px_valid && px_ready;
  assign last_px   = (x_q == X_LAST) && (y_q == Y_LAST);
  assign param_acc = param_valid && param_ready;

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (frame_start) state_d = ST_SCAN;
      ST_SCAN: if (px_acc && last_px) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    px_valid    = (state_q == ST_SCAN);
    frame_done  = (state_q == ST_DONE);
    busy        = (state_q != ST_IDLE);
    param_ready = !commit;
    state_dbg   = state_q;
  end

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    sh_m_d    = sh_m_q;
    sh_b_d    = sh_b_q;
    sh_v_d    = sh_v_q;
    act_m_d   = act_m_q;
    act_b_d   = act_b_q;
    lane_en_d = lane_en_q;
    ovl_d     = px_acc;
    ovr_d     = frame_start && (state_q != ST_IDLE);

    if (commit) begin
      x_d = 16'd0;
      y_d = 16'd0;
    end else if (px_acc) begin
      if (last_px) begin
        x_d = 16'd0;
        y_d = 16'd0;
      end else if (x_q == X_LAST) begin
        x_d = 16'd0;
        y_d = y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
    end

    // Lanes without a fresh write keep their previous active values.
    if (commit) begin
      for (int l = 0; l < 2; l++) begin
        if (sh_v_q[l]) begin
          act_m_d[l] = sh_m_q[l];
          act_b_d[l] = sh_b_q[l];
        end
      end
      lane_en_d = sh_v_q;
      sh_v_d    = 2'b00;
    end

    if (param_acc) begin
      sh_m_d[param_lane] = param_m;
      sh_b_d[param_lane] = param_b;
      sh_v_d[param_lane] = 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      x_q       <= 16'd0;
      y_q       <= 16'd0;
      sh_m_q    <= '0;
      sh_b_q    <= '0;
      sh_v_q    <= 2'b00;
      act_m_q   <= '0;
      act_b_q   <= '0;
      lane_en_q <= 2'b00;
      ovl_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      sh_m_q    <= sh_m_d;
      sh_b_q    <= sh_b_d;
      sh_v_q    <= sh_v_d;
      act_m_q   <= act_m_d;
      act_b_q   <= act_b_d;
      lane_en_q <= lane_en_d;
      ovl_q     <= ovl_d;
      ovr_q     <= ovr_d;
    end
  end

  assign x_coord       = x_q;
  assign y_coord       = y_q;
  assign m_left        = act_m_q[0];
  assign b_left        = act_b_q[0];
  assign m_right       = act_m_q[1];
  assign b_right       = act_b_q[1];
  assign lane_en       = lane_en_q;
  assign ovl_valid     = ovl_q;
  assign frame_overrun = ovr_q;

endmodule

// File: tb/tb_lane_overlay_ctrl.sv
// Bench for lane_overlay_ctrl on a 4x3 image: directed frames plus random traffic,
// checked every cycle against a pixel-index model of the frame sequencer.
module tb_lane_overlay_ctrl;
  localparam int W = 4;
  localparam int H = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pv = 1'b0, pl = 1'b0, fs = 1'b0, prdy = 1'b0;
  logic [15:0] pm = 16'd0, pb = 16'd0;

  logic        param_ready, px_valid, ovl_valid, frame_done, frame_overrun, busy;
  logic [15:0] x_coord, y_coord, m_left, b_left, m_right, b_right;
  logic [1:0]  lane_en, state_dbg;

  always #5 clk = ~clk;

  lane_overlay_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .CLK100MHZ(clk), .RESET(rst),
    .param_valid(pv), .param_ready(param_ready), .param_lane(pl),
    .param_m(pm), .param_b(pb),
    .frame_start(fs), .px_ready(prdy), .px_valid(px_valid),
    .x_coord(x_coord), .y_coord(y_coord),
    .m_left(m_left), .b_left(b_left), .m_right(m_right), .b_right(b_right),
    .lane_en(lane_en), .ovl_valid(ovl_valid), .frame_done(frame_done),
    .frame_overrun(frame_overrun), .busy(busy), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 scanning, 2 done; position kept as a linear pixel index.
  int          md_mode = 0;
  int          md_pix  = 0;
  logic [15:0] md_act_m [2];
  logic [15:0] md_act_b [2];
  logic [15:0] md_sh_m  [2];
  logic [15:0] md_sh_b  [2];
  logic [1:0]  md_sh_v = 2'b00;
  logic [1:0]  md_en   = 2'b00;
  logic        md_ovl  = 1'b0;
  logic        md_ovr  = 1'b0;

  task automatic model_reset();
    md_mode = 0;
    md_pix  = 0;
    for (int l = 0; l < 2; l++) begin
      md_act_m[l] = 16'd0; md_act_b[l] = 16'd0;
      md_sh_m[l]  = 16'd0; md_sh_b[l]  = 16'd0;
    end
    md_sh_v = 2'b00;
    md_en   = 2'b00;
    md_ovl  = 1'b0;
    md_ovr  = 1'b0;
  endtask

  task automatic model_step();
    logic start_now, take;
    start_now = (md_mode == 0) && fs;
    take      = pv && !start_now;
    md_ovl    = (md_mode == 1) && prdy;
    md_ovr    = fs && (md_mode != 0);
    if (start_now) begin
      for (int l = 0; l < 2; l++) begin
        if (md_sh_v[l]) begin
          md_act_m[l] = md_sh_m[l];
          md_act_b[l] = md_sh_b[l];
        end
      end
      md_en   = md_sh_v;
      md_sh_v = 2'b00;
      md_mode = 1;
      md_pix  = 0;
    end else if (md_mode == 1) begin
      if (prdy) begin
        md_pix++;
        if (md_pix == W * H) begin
          md_mode = 2;
          md_pix  = 0;
        end
      end
    end else if (md_mode == 2) begin
      md_mode = 0;
    end
    if (take) begin
      md_sh_m[pl] = pm;
      md_sh_b[pl] = pb;
      md_sh_v[pl] = 1'b1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Scoreboard of accepted coordinates ({y,x}) plus running pulse counters.
  logic [31:0] exp_q[$];
  logic        sb_en   = 1'b0;
  logic        cmp_en  = 1'b0;
  int          ovl_cnt = 0;
  int          done_cnt = 0;

  task automatic compare_all();
    check("px_valid",      32'(px_valid),      32'(md_mode == 1));
    check("x_coord",       32'(x_coord),       32'(md_pix % W));
    check("y_coord",       32'(y_coord),       32'(md_pix / W));
    check("frame_done",    32'(frame_done),    32'(md_mode == 2));
    check("busy",          32'(busy),          32'(md_mode != 0));
    check("state_dbg",     32'(state_dbg),     32'(md_mode));
    check("param_ready",   32'(param_ready),   32'(!((md_mode == 0) && fs)));
    check("m_left",        32'(m_left),        32'(md_act_m[0]));
    check("b_left",        32'(b_left),        32'(md_act_b[0]));
    check("m_right",       32'(m_right),       32'(md_act_m[1]));
    check("b_right",       32'(b_right),       32'(md_act_b[1]));
    check("lane_en",       32'(lane_en),       32'(md_en));
    check("ovl_valid",     32'(ovl_valid),     32'(md_ovl));
    check("frame_overrun", 32'(frame_overrun), 32'(md_ovr));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      compare_all();
      if (ovl_valid)  ovl_cnt++;
      if (frame_done) done_cnt++;
      if (sb_en && px_valid && prdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra_px: got {y,x}=%0h,%0h expected no more pixels", y_coord, x_coord);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          n_checks--;
          check("sb_coord", {y_coord, x_coord}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int ovl_base, done_base;

  task automatic arm_frame();
    exp_q.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back({16'(y), 16'(x)});
    ovl_base  = ovl_cnt;
    done_base = done_cnt;
    sb_en     = 1'b1;
    fs        = 1'b1;
  endtask

  // rdy_mode: 0 hold px_ready high, 1 toggle each cycle, 2 random
  task automatic wait_done(input string name, input int rdy_mode);
    int k;
    for (k = 0; k < 200; k++) begin
      if (frame_done) break;
      if (rdy_mode == 0) prdy = 1'b1;
      else if (rdy_mode == 1) prdy = ~prdy;
      else prdy = 1'($urandom_range(0, 1));
      tick();
    end
    if (k == 200) check({name, "_timeout"}, 32'(frame_done), 32'd1);
    tick();
    sb_en = 1'b0;
    check({name, "_ovl_pulses"}, 32'(ovl_cnt - ovl_base), 32'(W * H));
    check({name, "_done_pulses"}, 32'(done_cnt - done_base), 32'd1);
    check({name, "_sb_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic write_param(input logic lane, input logic [15:0] m, input logic [15:0] b);
    pv = 1'b1; pl = lane; pm = m; pb = b;
    tick();
    pv = 1'b0;
  endtask

  task automatic wait_pixel(input int x, input int y);
    int k;
    for (k = 0; k < 100; k++) begin
      if (x_coord == 16'(x) && y_coord == 16'(y)) break;
      tick();
    end
    if (k == 100) check("wait_pixel_timeout", {y_coord, x_coord}, {16'(y), 16'(x)});
  endtask

  initial begin
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    #1;
    check("rst_x", 32'(x_coord), 32'd0);
    check("rst_lane_en", 32'(lane_en), 32'd0);
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    // Frame 1: both lanes, full throughput.
    write_param(1'b0, 16'h0080, 16'd5);
    write_param(1'b1, 16'hFF80, 16'hFFFD);
    prdy = 1'b1;
    arm_frame();
    tick();
    fs = 1'b0;
    check("f1_m_left", 32'(m_left), 32'h0080);
    check("f1_b_left", 32'(b_left), 32'h0005);
    check("f1_m_right", 32'(m_right), 32'hFF80);
    check("f1_b_right", 32'(b_right), 32'hFFFD);
    check("f1_lane_en", 32'(lane_en), 32'h3);
    check("f1_first_px", {y_coord, x_coord}, 32'h0);
    wait_done("f1", 0);

    // Frame 2: right lane only, px_ready toggling.
    write_param(1'b1, 16'h0100, 16'h0020);
    arm_frame();
    tick();
    fs = 1'b0;
    check("f2_lane_en", 32'(lane_en), 32'h2);
    check("f2_m_left", 32'(m_left), 32'h0080);
    check("f2_b_left", 32'(b_left), 32'h0005);
    check("f2_m_right", 32'(m_right), 32'h0100);
    wait_done("f2", 1);

    // Frame 3: write collides with frame_start, then overrun mid-scan.
    prdy = 1'b1;
    pv = 1'b1; pl = 1'b0; pm = 16'h1234; pb = 16'h0007;
    arm_frame();
    #1;
    check("f3_ready_low", 32'(param_ready), 32'd0);
    tick();
    fs = 1'b0;
    #1;
    check("f3_ready_high", 32'(param_ready), 32'd1);
    tick();
    pv = 1'b0;
    check("f3_lane_en", 32'(lane_en), 32'h0);
    check("f3_m_left_kept", 32'(m_left), 32'h0080);
    wait_pixel(2, 1);
    fs = 1'b1;
    tick();
    fs = 1'b0;
    check("f3_overrun", 32'(frame_overrun), 32'd1);
    check("f3_no_recommit", 32'(m_left), 32'h0080);
    check("f3_still_scan", 32'(px_valid), 32'd1);
    wait_done("f3", 0);

    // Frame 4: shadowed left write lands; reset mid-frame aborts it.
    arm_frame();
    tick();
    fs = 1'b0;
    check("f4_lane_en", 32'(lane_en), 32'h1);
    check("f4_m_left", 32'(m_left), 32'h1234);
    check("f4_b_left", 32'(b_left), 32'h0007);
    prdy = 1'b1;
    wait_pixel(1, 1);
    sb_en = 1'b0;
    exp_q.delete();
    rst = 1'b1;
    #1;
    check("rst_mid_px_valid", 32'(px_valid), 32'd0);
    check("rst_mid_coord", {y_coord, x_coord}, 32'h0);
    check("rst_mid_m_left", 32'(m_left), 32'h0);
    check("rst_mid_b_right", 32'(b_right), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    check("rst_mid_no_done", 32'(done_cnt - done_base), 32'd0);
    arm_frame();
    tick();
    fs = 1'b0;
    check("f5_lane_en", 32'(lane_en), 32'h0);
    check("f5_first_px", {y_coord, x_coord}, 32'h0);
    wait_done("f5", 2);

    // Random traffic, checked by the model alone.
    for (int i = 0; i < 600; i++) begin
      pv   = 1'($urandom_range(0, 1));
      pl   = 1'($urandom_range(0, 1));
      pm   = 16'($urandom);
      pb   = 16'($urandom);
      prdy = ($urandom_range(0, 3) != 0);
      fs   = ($urandom_range(0, 9) == 0);
      tick();
    end
    pv = 1'b0;
    fs = 1'b0;
    prdy = 1'b1;
    for (int i = 0; i < 30; i++) tick();

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
